// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: RAM status, grant states, data word.
// No ports; imported by the arbiter, its interface and the bench.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IGNT = 2'd1,
      DGNT = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester and RAM signals around the shared RAM port.
// slave: arbiter side (takes requests, drives waits/loads/RAM strobes).
// master: environment side (requesters and RAM).
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();
   import cpu_types_pkg::*;

   logic              iREN;
   logic [ADDR_W-1:0] iaddr;
   logic              iwait;
   logic [DATA_W-1:0] iload;
   logic              dREN;
   logic              dWEN;
   logic [ADDR_W-1:0] daddr;
   logic [DATA_W-1:0] dstore;
   logic              dwait;
   logic [DATA_W-1:0] dload;
   logic              ramREN;
   logic              ramWEN;
   logic [ADDR_W-1:0] ramaddr;
   logic [DATA_W-1:0] ramstore;
   logic [DATA_W-1:0] ramload;
   ramstate_t         ramstate;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore,
      input  ramload, ramstate,
      output iwait, iload, dwait, dload,
      output ramREN, ramWEN, ramaddr, ramstore
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore,
      output ramload, ramstate,
      input  iwait, iload, dwait, dload,
      input  ramREN, ramWEN, ramaddr, ramstore
   );

endinterface

// File: rtl/arb_watchdog.sv
// Saturating up-counter with clear/enable; expire flags the enabled
// cycle that brings the count to MAX. Ports: clk, rst, clr, en, cnt, expire.
module arb_watchdog #(
   parameter int W   = 8,
   parameter int MAX = 255
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         expire
);

   localparam logic [W-1:0] MAXV  = W'(MAX);
   localparam logic [W-1:0] LASTV = W'(MAX - 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en && cnt_q != MAXV)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt    = cnt_q;
   assign expire = en && !clr && (cnt_q >= LASTV);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one RAM port between instruction fetch and data LW/SW.
// Ports: CLK, RST (async, active-high), bus (mem_arbiter_if.slave),
// timeout_err (sticky watchdog flag); with MEM_ARB_STATS_EN also
// icount/dcount (saturating completed-access counters).
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic          CLK,
   input  logic          RST,
   mem_arbiter_if.slave  bus,
   output logic          timeout_err
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [15:0]   icount,
   output logic [15:0]   dcount
`endif
);
   import cpu_types_pkg::*;

   localparam int WD_W = $clog2(TIMEOUT + 1);

   arb_state_t state_q, state_d;
   logic       last_d_q, last_d_d;
   logic       terr_q, terr_d;

   logic in_i, in_d, dreq, acc, err;
   logic req_held, i_done, d_done;
   logic wd_clr, wd_en, wd_expire;
   logic [WD_W-1:0] wdog_cnt_unused;

   assign in_i = (state_q == IGNT);
   assign in_d = (state_q == DGNT);
   assign dreq = bus.dREN | bus.dWEN;
   assign acc  = (bus.ramstate == ACCESS);
   assign err  = (bus.ramstate == ERROR);

   // A grant is only live while its requester still asks.
   assign req_held = (in_i & bus.iREN) | (in_d & dreq);
   assign i_done   = in_i & bus.iREN & acc;
   assign d_done   = in_d & dreq & acc;

   assign wd_clr = (state_q == IDLE);
   assign wd_en  = req_held & !acc & !err;

   arb_watchdog #(
      .W   (WD_W),
      .MAX (TIMEOUT)
   ) u_wdog (
      .clk    (CLK),
      .rst    (RST),
      .clr    (wd_clr),
      .en     (wd_en),
      .cnt    (wdog_cnt_unused),
      .expire (wd_expire)
   );

   always_comb begin
      state_d  = state_q;
      last_d_d = last_d_q;
      terr_d   = terr_q;
      unique case (state_q)
         IDLE: begin
            // Data wins, except right after a data completion
            // when a fetch is waiting.
            if (dreq && !(bus.iREN && last_d_q))
               state_d = DGNT;
            else if (bus.iREN)
               state_d = IGNT;
         end
         IGNT, DGNT: begin
            if (!req_held || acc || err) begin
               state_d = IDLE;
            end else if (wd_expire) begin
               state_d = IDLE;
               terr_d  = 1'b1;
            end
            if (i_done)
               last_d_d = 1'b0;
            if (d_done)
               last_d_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= IDLE;
         last_d_q <= 1'b0;
         terr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_d_q <= last_d_d;
         terr_q   <= terr_d;
      end
   end

   assign timeout_err = terr_q;

   always_comb begin
      bus.iwait    = 1'b1;
      bus.dwait    = 1'b1;
      bus.iload    = {DATA_W{1'b0}};
      bus.dload    = {DATA_W{1'b0}};
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
      bus.ramaddr  = {ADDR_W{1'b0}};
      bus.ramstore = {DATA_W{1'b0}};
      unique case (1'b1)
         in_i: begin
            bus.ramREN  = bus.iREN;
            bus.ramaddr = bus.iaddr;
            if (i_done) begin
               bus.iwait = 1'b0;
               bus.iload = bus.ramload;
            end
         end
         in_d: begin
            // Both strobes high is treated as a write.
            bus.ramWEN   = bus.dWEN;
            bus.ramREN   = bus.dREN & !bus.dWEN;
            bus.ramaddr  = bus.daddr;
            bus.ramstore = bus.dstore;
            if (d_done) begin
               bus.dwait = 1'b0;
               if (!bus.dWEN)
                  bus.dload = bus.ramload;
            end
         end
         default: ;
      endcase
   end

`ifdef MEM_ARB_STATS_EN
   logic icount_sat_unused, dcount_sat_unused;

   arb_watchdog #(
      .W   (16),
      .MAX (65535)
   ) u_icount (
      .clk    (CLK),
      .rst    (RST),
      .clr    (1'b0),
      .en     (i_done),
      .cnt    (icount),
      .expire (icount_sat_unused)
   );

   arb_watchdog #(
      .W   (16),
      .MAX (65535)
   ) u_dcount (
      .clk    (CLK),
      .rst    (RST),
      .clr    (1'b0),
      .en     (d_done),
      .cnt    (dcount),
      .expire (dcount_sat_unused)
   );
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single shared RAM port between the instruction-fetch requester and the data (LW/SW) requester of the pipeline.
- Produces the per-requester wait signals from which the pipeline derives ihit/dhit, which in turn drive pipeline stall and enable.
- Uses a registered grant FSM with data priority, an instruction anti-starvation guard, and a watchdog on RAM latency.

Parameters:
- ADDR_W, 32, width of word address.
- DATA_W, 32, width of data word.
- TIMEOUT, 255, maximum cycles a grant may wait for RAM ACCESS before aborting (must be ≥1).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset; asynchronous, active-high.
- iREN  in  1  instruction read request.
- iaddr  in  ADDR_W  instruction address.
- iwait  out  1  1 = instruction not ready. Low for exactly the completing cycle.
- iload  out  DATA_W  instruction data; valid when iwait=0.
- dREN  in  1  data read request.
- dWEN  in  1  data write request. dREN and dWEN both high is illegal; treat as a write.
- daddr  in  ADDR_W  data address.
- dstore  in  DATA_W  store data.
- dwait  out  1  1 = data access not complete.
- dload  out  DATA_W  load data; valid when dwait=0.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- timeout_err  out  1  sticky flag, set on watchdog expiry; cleared only by reset.

Behaviour:
- States: IDLE, IGNT, DGNT.
- Reset values: state=IDLE, last_d=0, wdog=0, timeout_err=0.
- Reset values of outputs: iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0.
- IDLE arbitration:
  - If (dREN|dWEN) and !(iREN & last_d), go to DGNT.
  - Else if iREN, go to IGNT.
  - Else stay in IDLE.
  - Effect: data wins ties, except immediately after a completed data access while iREN is pending.
- Grant registration: the grant takes effect on the next edge. Minimum latency from request to completion is 2 cycles (IDLE then GNT with ACCESS).
- IGNT:
  - ramREN=1, ramaddr=iaddr.
  - ramstate==ACCESS: iwait=0 and iload=ramload combinationally; last_d<=0; return to IDLE.
- DGNT:
  - ramWEN=dWEN, ramREN=dREN&!dWEN, ramaddr=daddr, ramstore=dstore.
  - ramstate==ACCESS: dwait=0 and dload=ramload (zero on writes); last_d<=1; return to IDLE.
- Non-granted requester sees wait=1 at all times.
- Requester drops its request mid-grant: return to IDLE next edge and drop RAM strobes; no wait pulse.
- ramstate==ERROR during a grant: wait stays 1; return to IDLE; the request re-arbitrates.
- Watchdog:
  - wdog clears on entry to any GNT state and counts while in GNT without ACCESS.
  - When wdog==TIMEOUT: set timeout_err, return to IDLE, wait stays 1.
  - wdog saturates and never wraps.
- Requester inputs may change while waiting; ram outputs track them combinationally. The requester holds its address stable until its wait=0.
- Reset asserted mid-grant: immediately forces the IDLE state and output reset values, asynchronously.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined:
  - Adds outputs icount[15:0] and dcount[15:0].
  - Each increments on a completed instruction or data access respectively and saturates at 16'hFFFF.
  - Both reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- The shared package (cpu_types_pkg) holds:
  - ramstate_t enum {FREE, BUSY, ACCESS, ERROR}.
  - arb_state_t enum {IDLE, IGNT, DGNT}.
  - word_t.
- One sub-module, arb_watchdog: a parameterised saturating counter with clear/enable and an expire output. It is reused by the stats counters when MEM_ARB_STATS_EN is defined.

Test Plan:
- Instruction fetch only:
  - Stimulus: iREN=1, iaddr=0x40; RAM returns ACCESS after 2 BUSY cycles with ramload=0x8C010004.
  - Response: IGNT entered cycle 1; iwait=0 with iload=0x8C010004 on cycle 3; back in IDLE on cycle 4.
- Data priority and anti-starvation:
  - Stimulus: iREN=1 and dREN=1 together from IDLE; RAM always ACCESS.
  - Response: DGNT first, then IGNT, then DGNT. Strict alternation; neither requester waits more than 2 grants.
- Store:
  - Stimulus: dWEN=1, daddr=0x100, dstore=0xDEADBEEF.
  - Response: ramWEN=1, ramREN=0, ramstore=0xDEADBEEF in DGNT; dwait=0 on the ACCESS cycle; dload=0.
- Watchdog:
  - Stimulus: TIMEOUT=4; RAM held BUSY.
  - Response: after 4 grant cycles timeout_err=1 (sticky), state IDLE, iwait stays 1; a subsequent ACCESS then completes normally.
- Error and abort:
  - Stimulus 1: ramstate=ERROR in DGNT.
  - Response 1: dwait stays 1; re-grant next arbitration.
  - Stimulus 2: iREN dropped mid-IGNT.
  - Response 2: IDLE next edge with ramREN=0.
- Reset mid-grant:
  - Stimulus: RST pulsed asynchronously in DGNT.
  - Response: all outputs return to reset values before the next edge; with MEM_ARB_STATS_EN, icount=dcount=0.
